// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace capture block.
// Covers the record layout, the serializer states and the drop counter limit.
package trace_pkg;

    localparam int          RECORD_W     = 96;
    localparam int          RECORD_BYTES = 12;
    localparam logic [15:0] DROP_MAX     = 16'hFFFF;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_e;

    // Field order sets the byte order on the wire: timestamp MSB goes out first.
    typedef struct packed {
        logic [31:0] timestamp;
        logic [31:0] instruction;
        logic [31:0] result;
    } trace_rec_t;

endpackage

// File: rtl/commit_trace_capture_if.sv
// Byte-stream valid/ready port carrying serialized trace records.
// The producer uses master and the consumer uses slave.
interface commit_trace_capture_if;

    logic [7:0] trace_data;
    logic       trace_valid;
    logic       trace_ready;

    modport master (output trace_data, output trace_valid, input trace_ready);
    modport slave  (input trace_data, input trace_valid, output trace_ready);

endinterface

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with show-ahead read data and a registered occupancy count.
// A write is accepted when full only if a read happens in the same cycle.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [RECORD_W-1:0]        wr_data,
    input  logic                       rd_en,
    output logic [RECORD_W-1:0]        rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [RECORD_W-1:0] mem_q [DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/commit_trace_capture.sv
// Logs every change of the processor instruction/result buses as a timestamped
// 96-bit record, buffers it and streams it out MSB-first as bytes.
module commit_trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                instruction,
    input  logic [31:0]                result,
    input  logic                       capture_en,
    commit_trace_capture_if.master     trace,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                drop_count
);

    logic [31:0]         ts_q, ts_d;
    logic                first_q, first_d;
    logic [63:0]         base_q, base_d;
    logic [15:0]         drop_q, drop_d;
    ser_state_e          state_q, state_d;
    logic [RECORD_W-1:0] shift_q, shift_d;
    logic [3:0]          idx_q, idx_d;

    logic                capture, push, pop;
    logic                fifo_empty, fifo_full;
    logic [RECORD_W-1:0] fifo_rd_data;
    trace_rec_t          new_rec;

    assign new_rec = '{timestamp: ts_q, instruction: instruction, result: result};
    assign capture = capture_en && (first_q || ({instruction, result} != base_q));
    assign pop     = (state_q == IDLE) && !fifo_empty;
    assign push    = capture && (!fifo_full || pop);

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (new_rec),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_level)
    );

    // A dropped record still moves the baseline so the same pair is not retried.
    always_comb begin
        ts_d    = ts_q + 32'd1;
        first_d = first_q;
        base_d  = base_q;
        drop_d  = drop_q;
        if (capture) begin
            first_d = 1'b0;
            base_d  = {instruction, result};
            if (!push && (drop_q != DROP_MAX)) drop_d = drop_q + 16'd1;
        end
    end

    // Bytes leave from the top of the shift register; zeros shifted in leave
    // trace_data at 0 once a record has fully gone out.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = SEND;
                    shift_d = fifo_rd_data;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (trace.trace_ready) begin
                    shift_d = {shift_q[RECORD_W-9:0], 8'h00};
                    if (idx_q == 4'(RECORD_BYTES - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q    <= '0;
            first_q <= 1'b1;
            base_q  <= '0;
            drop_q  <= '0;
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            ts_q    <= ts_d;
            first_q <= first_d;
            base_q  <= base_d;
            drop_q  <= drop_d;
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign trace.trace_valid = (state_q == SEND);
    assign trace.trace_data  = shift_q[RECORD_W-1 -: 8];
    assign drop_count        = drop_q;

endmodule
